// File: rtl/or1200_ack_gate_mc.sv
// Per-channel ack gate: holds cache/memory acks until an unstall token (or watchdog) releases them.
// Latency 1 cycle from ack_i or token to ack_o; no backpressure, acks beyond 2^CNT_W-1 pending are dropped and flagged.
module or1200_ack_gate_mc #(
   parameter int NCH         = 2,
   parameter int CNT_W       = 3,
   parameter int GATE_STORES = 0,
   parameter int TO_W        = 8,
   parameter int TIMEOUT     = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       ack_i,
   input  logic [NCH-1:0]       lsu_we,
   input  logic [NCH-1:0]       unstall_i,
   input  logic [NCH-1:0]       flush_i,
   output logic [NCH-1:0]       ack_o,
   output logic [NCH*CNT_W-1:0] pending_o,
   output logic [NCH-1:0]       overflow_o,
   output logic [NCH-1:0]       timeout_o
);

   localparam logic [CNT_W-1:0] PEND_MAX = '1;
   localparam bit               GS       = (GATE_STORES != 0);

   typedef enum logic {IDLE, WAIT} ch_state_e;

   for (genvar n = 0; n < NCH; n++) begin : g_ch
      logic [CNT_W-1:0] pend_q, pend_d;
      logic             ack_q, ovf_q, ovf_set;
      logic             gated, passthru, rel_tok, rel_wd, rel;
      ch_state_e        state;

      assign state    = (pend_q != '0) ? WAIT : IDLE;
      assign gated    = ack_i[n] & (~lsu_we[n] | GS);
      assign passthru = ack_i[n] & ~gated;
      // A pass-through ack owns the output this cycle, so any release waits.
      assign rel_tok  = unstall_i[n] & ((state == WAIT) | gated) & ~passthru;
      assign rel      = rel_tok | rel_wd;

      always_comb begin
         pend_d  = pend_q;
         ovf_set = 1'b0;
         case ({gated, rel})
            2'b10: begin
               if (pend_q == PEND_MAX) ovf_set = 1'b1;
               else                    pend_d  = pend_q + CNT_W'(1);
            end
            2'b01:   pend_d = pend_q - CNT_W'(1);
            default: pend_d = pend_q;
         endcase
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            ack_q  <= 1'b0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
         end else if (flush_i[n]) begin
            ack_q  <= 1'b0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
         end else begin
            ack_q  <= passthru | rel;
            pend_q <= pend_d;
            if (ovf_set) ovf_q <= 1'b1;
         end
      end

      if (TIMEOUT != 0) begin : g_wd
         localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);
         logic [TO_W-1:0] wd_q;
         logic            to_q;

         assign rel_wd = (state == WAIT) & (wd_q == WD_LAST) & ~rel_tok & ~passthru;

         // wd holds at WD_LAST while a pass-through blocks the forced release.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               wd_q <= '0;
               to_q <= 1'b0;
            end else if (flush_i[n]) begin
               wd_q <= '0;
               to_q <= 1'b0;
            end else begin
               to_q <= rel_wd;
               if (rel || state == IDLE) wd_q <= '0;
               else if (wd_q != WD_LAST) wd_q <= wd_q + TO_W'(1);
            end
         end

         assign timeout_o[n] = to_q;
      end else begin : g_nowd
         assign rel_wd       = 1'b0;
         assign timeout_o[n] = 1'b0;
      end

      assign ack_o[n]                      = ack_q;
      assign overflow_o[n]                 = ovf_q;
      assign pending_o[n*CNT_W +: CNT_W]   = pend_q;
   end

endmodule
